// File: rtl/sum_block_accumulator.sv
// rtl/sum_block_accumulator.sv - accumulates COUNT sum samples into a block total and block maximum
module sum_block_accumulator #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  localparam int ACC_W = WIDTH + $clog2(COUNT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [ACC_W-1:0] o_out_sum,
  output logic [WIDTH-1:0] o_out_max,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  localparam int CNT_W = $clog2(COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [WIDTH-1:0]   r_max;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_out_sum;
  logic [WIDTH-1:0]   r_out_max;
  logic               w_xfer;
  logic               w_last;
  logic [ACC_W-1:0]   w_sum;
  logic [WIDTH-1:0]   w_max;

  assign w_last = (r_cnt == CNT_W'(COUNT - 1));
  assign w_sum  = r_acc + {{(ACC_W-WIDTH){1'b0}}, i_in_data};
  // The first sample of a block seeds the maximum regardless of stale state.
  assign w_max  = ((r_cnt == '0) || (i_in_data > r_max)) ? i_in_data : r_max;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs; in_ready depends only on state, en and clear.
  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        o_in_ready = i_en & ~i_clear;
        w_xfer     = o_in_ready & i_in_valid;
        if (!i_en) begin
          w_next = S_IDLE;
        end else if (w_xfer && w_last) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = i_en ? S_ACCUM : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Accumulator, running maximum, sample count and the registered block result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc     <= '0;
      r_max     <= '0;
      r_cnt     <= '0;
      r_out_sum <= '0;
      r_out_max <= '0;
    end else if (i_clear && (r_state != S_HOLD)) begin
      r_acc <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_out_sum <= w_sum;
        r_out_max <= w_max;
        r_acc     <= '0;
        r_max     <= '0;
        r_cnt     <= '0;
      end else begin
        r_acc <= w_sum;
        r_max <= w_max;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_out_sum = r_out_sum;
  assign o_out_max = r_out_max;

endmodule

// File: tb/tb_sum_block_accumulator.sv
// tb/tb_sum_block_accumulator.sv - scoreboard bench for sum_block_accumulator
module tb_sum_block_accumulator;

  localparam int WIDTH = 8;
  localparam int ACC_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic [WIDTH-1:0] out_max;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [WIDTH-1:0] max;
  } result_t;

  result_t exp_q[$];

  sum_block_accumulator #(.WIDTH(8), .COUNT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_clear     (clear),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_sum   (out_sum),
    .o_out_max   (out_max),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("sb_sum", int'(out_sum), int'(e.sum));
        check("sb_max", int'(out_max), int'(e.max));
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d,
                       input int esum, input int emax);
    result_t r;
    r.sum = ACC_W'(esum);
    r.max = WIDTH'(emax);
    exp_q.push_back(r);
    send(WIDTH'(a));
    send(WIDTH'(b));
    send(WIDTH'(c));
    send(WIDTH'(d));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_max", int'(out_max), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;

    // Basic block, 1-cycle latency, single-cycle out_valid pulse, retention.
    send4(10, 20, 30, 40, 100, 40);
    check("t1_valid_rise", int'(out_valid), 1);
    @(negedge clk);
    check("t1_valid_fall", int'(out_valid), 0);
    check("t1_sum_retained", int'(out_sum), 100);
    check("t1_max_retained", int'(out_max), 40);

    // Full-scale samples, no wrap.
    send4(255, 255, 255, 255, 1020, 255);
    @(negedge clk);

    // Backpressure: result stable, input blocked with a sample pending.
    out_ready = 1'b0;
    send4(1, 2, 3, 4, 10, 4);
    in_data  = 8'd99;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_valid", int'(out_valid), 1);
      check("t3_hold_sum", int'(out_sum), 10);
      check("t3_hold_max", int'(out_max), 4);
      check("t3_hold_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t3_after_accept", int'(out_valid), 0);

    // Clear discards the partial block and beats a coincident sample.
    send(8'd50);
    send(8'd60);
    @(negedge clk);
    clear    = 1'b1;
    in_data  = 8'd77;
    in_valid = 1'b1;
    #1;
    check("t4_clear_in_ready", int'(in_ready), 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    send4(5, 6, 7, 8, 26, 8);
    @(negedge clk);

    // Enable drop pauses and retains the partial block.
    send(8'd7);
    send(8'd9);
    @(negedge clk);
    en       = 1'b0;
    in_data  = 8'd200;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_en_low_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    en = 1'b1;
    begin
      result_t r;
      r.sum = ACC_W'(40);
      r.max = WIDTH'(13);
      exp_q.push_back(r);
    end
    send(8'd11);
    send(8'd13);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-block.
    send(8'd3);
    send(8'd4);
    #2;
    rst = 1'b1;
    #1;
    check("t6_mid_in_ready", int'(in_ready), 0);
    check("t6_mid_out_valid", int'(out_valid), 0);
    check("t6_mid_out_sum", int'(out_sum), 0);
    check("t6_mid_out_max", int'(out_max), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset during HOLD: the held result is dropped.
    out_ready = 1'b0;
    send(8'd2);
    send(8'd2);
    send(8'd2);
    send(8'd2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t6_hold_valid", int'(out_valid), 1);
    check("t6_hold_sum", int'(out_sum), 8);
    #2;
    rst = 1'b1;
    #1;
    check("t6_hold_rst_valid", int'(out_valid), 0);
    check("t6_hold_rst_sum", int'(out_sum), 0);
    check("t6_hold_rst_max", int'(out_max), 0);
    check("t6_hold_rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send4(1, 1, 1, 1, 4, 1);
    repeat (3) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog keeps the run bounded even if a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
- Downstream consumer of the 8-bit operand-sum stream produced by the adder stage.
- Accepts sums over a valid/ready handshake and accumulates COUNT consecutive samples into one block result.
- Presents the block total plus the block maximum on a second valid/ready interface, for the readout/serialiser stage.
- One clock domain; reset is asynchronous and active-high.

Parameters:
- WIDTH, 8, width of each incoming sum sample.
- COUNT, 4, samples per block. Must be ≥2 and a power of two.
- ACC_W, WIDTH+$clog2(COUNT), accumulator/result width. Derived value; never overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low freezes input acceptance.
- clear  input  1  synchronous discard of the partial block.
- in_data  input  WIDTH  sum sample from the adder stage.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- out_sum  output  ACC_W  total of the completed block.
- out_max  output  WIDTH  largest sample in the completed block.
- out_valid  output  1  out_sum/out_max are valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst=1, any time, asynchronous):
  - state=IDLE; acc=0; max=0; cnt=0.
  - in_ready=0, out_valid=0, out_sum=0, out_max=0.
- States and transitions:
  - IDLE: in_ready=0. Goes to ACCUM on the next edge when en=1.
  - ACCUM: in_ready=en. When en=0, goes to IDLE; acc/max/cnt are retained and the block resumes later.
  - HOLD: out_valid=1, in_ready=0. Returns to ACCUM (en=1) or IDLE (en=0) on the edge where out_ready=1.
- Input transfer: occurs on an edge where in_valid&in_ready.
  - acc += in_data, zero-extended to ACC_W. ACC_W guarantees no overflow.
  - max = larger of max and in_data. The first sample of a block loads max directly.
  - cnt increments.
- Block completion: on the transfer with cnt==COUNT-1:
  - registered out_sum = acc+in_data and out_max are loaded.
  - state goes to HOLD; out_valid rises the next cycle (1-cycle latency from the last transfer).
  - acc, max and cnt clear to 0 in the same edge.
- HOLD outputs: out_sum and out_max stay stable while out_valid=1 and out_ready=0. in_valid is ignored, with no sample loss; the upstream stage holds its data.
- Result transfer: on out_valid&out_ready, out_valid drops the next cycle. out_sum/out_max keep their last values; they are don't-care when out_valid=0, but the bench checks they are retained.
- Back-to-back throughput: COUNT+1 cycles per block minimum, because the HOLD cycle blocks input.
- clear=1:
  - In ACCUM/IDLE: acc, max and cnt become 0 and no transfer is accepted that cycle (in_ready forced 0).
  - In HOLD: no effect; a completed result is never discarded.
- Simultaneous clear and in_valid: clear wins and the sample is not consumed.
- en falling while in HOLD: the result remains presented until accepted.
- in_data and out_ready are sampled only at the rising edge. No combinational path from in_valid to in_ready.

Test Plan:
- Reset then en=1; send 10,20,30,40 with in_valid held and out_ready=1 → one cycle after the 4th transfer, out_valid=1, out_sum=100, out_max=40. out_valid is high for exactly 1 cycle.
- Send 255 ×4 → out_sum=1020 (0x3FC, 10 bits), out_max=255; no wrap.
- Complete a block of 1,2,3,4 with out_ready=0 for 5 cycles → out_valid, out_sum=10 and out_max=4 stable; in_ready=0 throughout. Raising out_ready gives one transfer; the next block then starts fresh.
- Send 50,60, pulse clear, then send 5,6,7,8 → out_sum=26, out_max=8. A clear coincident with in_valid=1 does not consume that sample.
- Send 7,9, drop en for 3 cycles (in_ready=0), restore en, send 11,13 → out_sum=40, out_max=13.
- Assert rst asynchronously mid-block and again during HOLD → outputs immediately go to 0 (out_valid=0, in_ready=0). After release, a new block of 1,1,1,1 gives out_sum=4.
